synth_voice_scheduler: RTL and testbench

- Per-sample sequencer for the shared voice datapath (oscillator/envelope engine) in the synthesizer.
- On each sample tick from the synth clock generator, it walks the enabled voices one at a time and requests one output sample per voice over a req/ack handshake.
- It accumulates the returned samples and emits one scaled, saturated mix sample per tick to the output stage.

---
 rtl/synth_voice_scheduler_if.sv | 14 +
 rtl/synth_voice_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_synth_voice_scheduler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/synth_voice_scheduler_if.sv
// Request/acknowledge bundle between the voice scheduler (master) and the
// shared oscillator/envelope datapath (slave). Dp_sample is valid with Dp_ack.
interface synth_voice_scheduler_if #(
  parameter int VW = 2,
  parameter int SW = 16
);
  logic                 Dp_req;
  logic [VW-1:0]        Dp_voice;
  logic                 Dp_ack;
  logic signed [SW-1:0] Dp_sample;

  modport master (output Dp_req, Dp_voice, input Dp_ack, Dp_sample);
  modport slave  (input Dp_req, Dp_voice, output Dp_ack, Dp_sample);
endinterface

// File: rtl/synth_voice_scheduler.sv
// Per-sample voice sequencer. On each enabled sample tick it walks the voice
// mask captured at frame start, requests one sample per enabled voice from the
// shared datapath, accumulates them and emits one shifted, saturated mix.
// Optional feature macro: SYNTH_SCHED_TIMEOUT_EN -- when defined, a voice that
// is not acked within ACK_TIMEOUT cycles contributes 0 and sets Dp_timeout.
module synth_voice_scheduler #(
  parameter int NUM_VOICES  = 4,
  parameter int VW          = 2,
  parameter int SW          = 16,
  parameter int MIX_SHIFT   = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                       Sys_clk,
  input  logic                       Syn_rst,
  input  logic                       Syn_ce,
  input  logic                       Syn_tick,
  input  logic [NUM_VOICES-1:0]      Voice_en,
  synth_voice_scheduler_if.master    dp,
  output logic signed [SW-1:0]       Mix_out,
  output logic                       Mix_valid,
  output logic                       Busy,
  output logic                       Overrun,
  output logic                       Dp_timeout
);
  // Accumulator is wide enough for NUM_VOICES full-scale samples.
  localparam int            AW   = SW + VW;
  localparam logic [VW-1:0] LAST = VW'(NUM_VOICES - 1);

  if (VW != $clog2(NUM_VOICES) || NUM_VOICES < 2 ||
      (NUM_VOICES & (NUM_VOICES - 1)) != 0 || ACK_TIMEOUT < 1) begin : g_bad_params
    $error("synth_voice_scheduler: inconsistent parameters");
  end

  typedef enum logic [1:0] {IDLE, SCAN, REQ, DONE} state_t;

  state_t                state_q, state_d;
  logic [VW-1:0]         idx_q, idx_d, idx_next;
  logic [NUM_VOICES-1:0] mask_q, mask_d;
  logic signed [AW-1:0]  acc_q, acc_d, sample_ext, shifted;
  logic                  req_q, req_d;
  logic [VW-1:0]         voice_q, voice_d;
  logic signed [SW-1:0]  mix_q, mix_d, mix_sat;
  logic                  mix_valid_q, mix_valid_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic                  accept, timeout_hit;

  assign idx_next   = idx_q + 1'b1;
  assign sample_ext = {{VW{dp.Dp_sample[SW-1]}}, dp.Dp_sample};
  // A request retires on an ack, or on a timeout when that feature is built in.
  assign accept     = req_q && (dp.Dp_ack || timeout_hit);

  // Scale the accumulator and clamp it into the signed SW-bit output range.
  always_comb begin
    shifted = acc_q >>> MIX_SHIFT;
    if ((&shifted[AW-1:SW-1]) || !(|shifted[AW-1:SW-1])) mix_sat = shifted[SW-1:0];
    else if (shifted[AW-1])                              mix_sat = {1'b1, {(SW-1){1'b0}}};
    else                                                 mix_sat = {1'b0, {(SW-1){1'b1}}};
  end

  // Next-state and next-output logic of the frame sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    acc_d       = acc_q;
    req_d       = req_q;
    voice_d     = voice_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    busy_d      = busy_q;
    // A tick that cannot start a frame is dropped and remembered as an overrun.
    overrun_d   = overrun_q | (Syn_tick && state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (Syn_tick && Syn_ce) begin
          mask_d  = Voice_en;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (mask_q[idx_q]) begin
          req_d   = 1'b1;
          voice_d = idx_q;
          state_d = REQ;
        end else if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_next;
        end
      end
      REQ: begin
        if (accept) begin
          if (dp.Dp_ack) acc_d = acc_q + sample_ext;
          if (idx_q == LAST) begin
            req_d   = 1'b0;
            state_d = DONE;
          end else begin
            idx_d = idx_next;
            // Back-to-back request when the neighbour is enabled; otherwise
            // let SCAN skip the disabled voices one per cycle.
            if (mask_q[idx_next]) begin
              voice_d = idx_next;
            end else begin
              req_d   = 1'b0;
              state_d = SCAN;
            end
          end
        end
      end
      DONE: begin
        mix_d       = mix_sat;
        mix_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset wins over every in-flight frame.
  always_ff @(posedge Sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (Syn_rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mask_q      <= '0;
      acc_q       <= '0;
      req_q       <= 1'b0;
      voice_q     <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      acc_q       <= acc_d;
      req_q       <= req_d;
      voice_q     <= voice_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SYNTH_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] to_cnt_q;
  logic          timeout_q;

  assign timeout_hit = (state_q == REQ) && !dp.Dp_ack && (to_cnt_q == TW'(ACK_TIMEOUT - 1));

  // Count waiting cycles of the current request; any retirement restarts it.
  always_ff @(posedge Sys_clk) begin
    if (Syn_rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= (state_q == REQ && !accept) ? to_cnt_q + 1'b1 : '0;
      timeout_q <= timeout_q | timeout_hit;
    end
  end

  assign Dp_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign Dp_timeout  = 1'b0;
`endif

  assign dp.Dp_req   = req_q;
  assign dp.Dp_voice = voice_q;
  assign Mix_out     = mix_q;
  assign Mix_valid   = mix_valid_q;
  assign Busy        = busy_q;
  assign Overrun     = overrun_q;
endmodule

// File: tb/tb_synth_voice_scheduler.sv
// Bench for synth_voice_scheduler. Two instances share all stimulus: one with
// the default mix shift and one with MIX_SHIFT=0, so both scalings are checked
// on every frame. The bench plays the datapath and predicts each frame from
// the enabled voices, their ack delays and their samples.
module tb_synth_voice_scheduler;
  localparam int NV = 4;
  localparam int VW = 2;
  localparam int SW = 16;
  localparam int TO = 16;

  logic                 clk = 1'b0;
  logic                 rst, ce, tick, ack;
  logic [NV-1:0]        ven;
  logic signed [SW-1:0] sample;
  logic signed [SW-1:0] mix_a, mix_b;
  logic                 mv_a, mv_b, busy_a, busy_b, ovr_a, ovr_b, to_a, to_b;

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  ovr_exp = 1'b0;
  bit  to_exp  = 1'b0;
  int  dly[NV];
  logic signed [SW-1:0] smp[NV];

  synth_voice_scheduler_if #(.VW(VW), .SW(SW)) dp_a ();
  synth_voice_scheduler_if #(.VW(VW), .SW(SW)) dp_b ();

  assign dp_a.Dp_ack    = ack;
  assign dp_a.Dp_sample = sample;
  assign dp_b.Dp_ack    = ack;
  assign dp_b.Dp_sample = sample;

  synth_voice_scheduler #(.NUM_VOICES(NV), .VW(VW), .SW(SW), .MIX_SHIFT(2), .ACK_TIMEOUT(TO)) u_dut (
    .Sys_clk(clk), .Syn_rst(rst), .Syn_ce(ce), .Syn_tick(tick), .Voice_en(ven),
    .dp(dp_a.master), .Mix_out(mix_a), .Mix_valid(mv_a), .Busy(busy_a),
    .Overrun(ovr_a), .Dp_timeout(to_a)
  );

  synth_voice_scheduler #(.NUM_VOICES(NV), .VW(VW), .SW(SW), .MIX_SHIFT(0), .ACK_TIMEOUT(TO)) u_dut0 (
    .Sys_clk(clk), .Syn_rst(rst), .Syn_ce(ce), .Syn_tick(tick), .Voice_en(ven),
    .dp(dp_b.master), .Mix_out(mix_b), .Mix_valid(mv_b), .Busy(busy_b),
    .Overrun(ovr_b), .Dp_timeout(to_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expd);
    n_chk++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expd);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // One frame: tick, act as datapath with per-voice ack delays from dly[]
  // (negative = never ack), optionally inject a second tick mid-frame.
  task automatic run_frame(input string tag, input logic [NV-1:0] mask,
                           input bit noise, input int mid_tick);
    int sum = 0, lat = 1, req_cyc = 0;
    int q_exp[$], q_obs[$];
    int got_lat = -1, valids = 0, obs_req = 0, diff = 0, cur = -1, wcnt = 0;
    bit to_frame = 1'b0;
    logic signed [SW-1:0] ma = 'x, mb = 'x;

    // Expected frame: one SCAN cycle per voice not reached back-to-back,
    // delay+1 REQ cycles per enabled voice, then the DONE cycle.
    for (int i = 0; i < NV; i++) begin
      if (mask[i]) begin
        if (i == 0 || !mask[i-1]) lat++;
        if (dly[i] < 0) begin
          lat += TO; req_cyc += TO; to_frame = 1'b1;
        end else begin
          lat += dly[i] + 1; req_cyc += dly[i] + 1;
          sum += smp[i]; q_exp.push_back(i);
        end
      end else begin
        lat++;
      end
    end

    @(negedge clk);
    ce = 1'b1; tick = 1'b1; ven = mask;
    for (int cyc = 0; cyc < 400 && (got_lat < 0 || cyc <= got_lat + 3); cyc++) begin
      @(negedge clk);
      tick = (cyc == mid_tick);
      ven  = NV'($urandom);
      ce   = 1'($urandom_range(0, 1));
      if (cyc == 0) check({tag, " busy_start"}, busy_a, 1);
      if (mv_a) begin
        valids++;
        if (got_lat < 0) begin
          got_lat = cyc; ma = mix_a; mb = mix_b;
          check({tag, " busy_end"}, busy_a, 0);
        end
      end
      if (dp_b.Dp_req !== dp_a.Dp_req || dp_b.Dp_voice !== dp_a.Dp_voice || mv_b !== mv_a) diff++;
      ack = 1'b0;
      sample = noise ? SW'($urandom) : '0;
      if (dp_a.Dp_req) begin
        obs_req++;
        if (int'(dp_a.Dp_voice) != cur) begin
          cur = int'(dp_a.Dp_voice); wcnt = 0;
        end else begin
          wcnt++;
        end
        if (dly[cur] >= 0 && wcnt >= dly[cur]) begin
          ack = 1'b1; sample = smp[cur]; q_obs.push_back(cur);
        end
      end else begin
        cur = -1;
        ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    tick = 1'b0; ack = 1'b0;
    if (mid_tick >= 0) ovr_exp = 1'b1;
    if (to_frame) to_exp = 1'b1;

    check({tag, " latency"}, got_lat, lat);
    check({tag, " valids"}, valids, 1);
    check({tag, " mix_shift2"}, ma, sat16(sum >>> 2));
    check({tag, " mix_shift0"}, mb, sat16(sum));
    check({tag, " req_cycles"}, obs_req, req_cyc);
    check({tag, " nvoices"}, q_obs.size(), q_exp.size());
    for (int i = 0; i < q_exp.size() && i < q_obs.size(); i++)
      check({tag, " voice_order"}, q_obs[i], q_exp[i]);
    check({tag, " twin_diff"}, diff, 0);
    check({tag, " overrun"}, ovr_a, ovr_exp);
    check({tag, " timeout"}, to_a, to_exp);
  endtask

  initial begin
    int mv_seen;
    rst = 1'b1; ce = 1'b0; tick = 1'b0; ven = '0; ack = 1'b0; sample = '0;
    repeat (3) @(negedge clk);
    check("rst dp_req",   dp_a.Dp_req, 0);
    check("rst dp_voice", dp_a.Dp_voice, 0);
    check("rst mix_out",  mix_a, 0);
    check("rst mix_valid", mv_a, 0);
    check("rst busy",     busy_a, 0);
    check("rst overrun",  ovr_a, 0);
    check("rst timeout",  to_a, 0);
    rst = 1'b0;

    // Tick with the scheduler disabled: ignored, not an overrun.
    @(negedge clk); tick = 1'b1; ce = 1'b0; ven = '1;
    @(negedge clk); tick = 1'b0;
    repeat (3) @(negedge clk);
    check("ce_off busy", busy_a, 0);
    check("ce_off overrun", ovr_a, 0);

    dly = '{0, 0, 0, 0};
    smp = '{16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000};
    run_frame("all_on", 4'b1111, 1'b0, -1);

    smp = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
    run_frame("mask_0101", 4'b0101, 1'b0, -1);
    run_frame("mask_0000", 4'b0000, 1'b0, -1);
    run_frame("max_pos", 4'b1111, 1'b0, -1);

    smp = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000};
    run_frame("max_neg", 4'b1111, 1'b0, -1);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NV; i++) begin
        smp[i] = SW'($urandom);
        dly[i] = $urandom_range(0, 3);
      end
      run_frame("random", NV'($urandom), 1'b1, -1);
    end

    dly = '{10, 10, 10, 10};
    smp = '{-16'sd500, 16'sd700, -16'sd900, 16'sd1100};
    run_frame("overrun", 4'b1111, 1'b0, 5);
    dly = '{1, 0, 2, 0};
    run_frame("after_overrun", 4'b1011, 1'b0, -1);

`ifdef SYNTH_SCHED_TIMEOUT_EN
    dly = '{0, 0, -1, 0};
    smp = '{16'sd100, 16'sd200, 16'sd300, 16'sd400};
    run_frame("timeout", 4'b1111, 1'b0, -1);
`endif

    // Reset while waiting on voice 1: request drops, no mix, flags clear.
    @(negedge clk); ce = 1'b1; tick = 1'b1; ven = '1;
    @(negedge clk); tick = 1'b0;
    for (int k = 0; k < 20 && !(dp_a.Dp_req && dp_a.Dp_voice == 2'd1); k++) begin
      ack = dp_a.Dp_req && dp_a.Dp_voice == 2'd0;
      sample = 16'sd1234;
      @(negedge clk);
    end
    ack = 1'b0;
    check("midrst reached_v1", dp_a.Dp_req && dp_a.Dp_voice == 2'd1, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst dp_req",  dp_a.Dp_req, 0);
    check("midrst busy",    busy_a, 0);
    check("midrst overrun", ovr_a, 0);
    check("midrst timeout", to_a, 0);
    check("midrst mix_out", mix_a, 0);
    mv_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mv_a) mv_seen++;
    end
    check("midrst no_valid", mv_seen, 0);
    check("midrst idle", busy_a, 0);
    ovr_exp = 1'b0; to_exp = 1'b0;

    dly = '{0, 3, 0, 1};
    smp = '{16'sd4000, -16'sd8000, 16'sd12000, -16'sd16000};
    run_frame("post_rst", 4'b1110, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog");
  end
endmodule
